// File: rtl/fib_checker_if.sv
// Term stream and check-result bundle between a Fibonacci generator and fib_checker.
// FIB_CHECK_OVF_EN adds the ovf result line.
interface fib_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) ();
  logic             en;
  logic [WIDTH-1:0] fn;
  logic             match;
  logic             mismatch;
  logic             err;
  logic [CNT_W-1:0] term_cnt;
  logic [WIDTH-1:0] expected;
`ifdef FIB_CHECK_OVF_EN
  logic             ovf;

  modport master (
    output en, fn,
    input  match, mismatch, err, term_cnt, expected, ovf
  );
  modport slave (
    input  en, fn,
    output match, mismatch, err, term_cnt, expected, ovf
  );
`else
  modport master (
    output en, fn,
    input  match, mismatch, err, term_cnt, expected
  );
  modport slave (
    input  en, fn,
    output match, mismatch, err, term_cnt, expected
  );
`endif
endinterface

// File: rtl/fib_checker.sv
// Self-check for a Fibonacci term stream: predicts each term from the last two accepted ones.
// Optional FIB_CHECK_OVF_EN flags matched terms whose prediction wrapped modulo 2^WIDTH.
module fib_checker #(
  parameter int               WIDTH  = 4,
  parameter int               CNT_W  = 8,
  parameter logic [WIDTH-1:0] SEED_A = WIDTH'(1),
  parameter logic [WIDTH-1:0] SEED_B = WIDTH'(1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  fib_checker_if.slave  bus
);

  typedef enum logic [1:0] {SEED0, SEED1, TRACK, FAIL} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] prev_a_reg, prev_a_next;
  logic [WIDTH-1:0] prev_b_reg, prev_b_next;
  logic [WIDTH-1:0] expected_reg, expected_next;
  logic [CNT_W-1:0] term_cnt_reg, term_cnt_next;
  logic             match_reg, match_next;
  logic             mismatch_reg, mismatch_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] sum;
  logic [CNT_W-1:0] cnt_inc;

`ifdef FIB_CHECK_OVF_EN
  logic             sum_carry;
  logic             carry_reg, carry_next;
  logic             ovf_reg, ovf_next;
  assign {sum_carry, sum} = {1'b0, prev_b_reg} + {1'b0, bus.fn};
`else
  assign sum = prev_b_reg + bus.fn;
`endif

  // Counter saturates at all-ones instead of wrapping.
  assign cnt_inc = (term_cnt_reg == {CNT_W{1'b1}}) ? term_cnt_reg : term_cnt_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    prev_a_next   = prev_a_reg;
    prev_b_next   = prev_b_reg;
    expected_next = expected_reg;
    term_cnt_next = term_cnt_reg;
    err_next      = err_reg;
    match_next    = 1'b0;
    mismatch_next = 1'b0;
`ifdef FIB_CHECK_OVF_EN
    carry_next    = carry_reg;
    ovf_next      = 1'b0;
`endif
    case (state_reg)
      SEED0: begin
        if (bus.en) begin
          if (bus.fn == SEED_A) begin
            match_next    = 1'b1;
            prev_b_next   = bus.fn;
            expected_next = SEED_B;
            term_cnt_next = cnt_inc;
            state_next    = SEED1;
`ifdef FIB_CHECK_OVF_EN
            carry_next    = 1'b0;
`endif
          end else begin
            mismatch_next = 1'b1;
            err_next      = 1'b1;
            state_next    = FAIL;
          end
        end
      end
      SEED1, TRACK: begin
        // In SEED1 expected_reg holds SEED_B, so both states share one compare.
        if (bus.en) begin
          if (bus.fn == expected_reg) begin
            match_next    = 1'b1;
            prev_a_next   = prev_b_reg;
            prev_b_next   = bus.fn;
            expected_next = sum;
            term_cnt_next = cnt_inc;
            state_next    = TRACK;
`ifdef FIB_CHECK_OVF_EN
            ovf_next      = carry_reg;
            carry_next    = sum_carry;
`endif
          end else begin
            mismatch_next = 1'b1;
            err_next      = 1'b1;
            state_next    = FAIL;
          end
        end
      end
      FAIL: begin
        state_next = FAIL;
      end
      default: begin
        state_next = SEED0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state_reg    <= SEED0;
      prev_a_reg   <= '0;
      prev_b_reg   <= '0;
      expected_reg <= SEED_A;
      term_cnt_reg <= '0;
      match_reg    <= 1'b0;
      mismatch_reg <= 1'b0;
      err_reg      <= 1'b0;
`ifdef FIB_CHECK_OVF_EN
      carry_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      prev_a_reg   <= prev_a_next;
      prev_b_reg   <= prev_b_next;
      expected_reg <= expected_next;
      term_cnt_reg <= term_cnt_next;
      match_reg    <= match_next;
      mismatch_reg <= mismatch_next;
      err_reg      <= err_next;
`ifdef FIB_CHECK_OVF_EN
      carry_reg    <= carry_next;
      ovf_reg      <= ovf_next;
`endif
    end
  end

  assign bus.match    = match_reg;
  assign bus.mismatch = mismatch_reg;
  assign bus.err      = err_reg;
  assign bus.term_cnt = term_cnt_reg;
  assign bus.expected = expected_reg;
`ifdef FIB_CHECK_OVF_EN
  assign bus.ovf      = ovf_reg;
`endif

  // While tracking, the prediction is always the sum of the two held terms.
  a_track_sum: assert property (@(posedge clk) disable iff (!rst || clr)
    (state_reg == TRACK) |-> (expected_reg == prev_a_reg + prev_b_reg));

endmodule
